// File: rtl/mod997_pkg.sv
// Shared types and constants for the mod-997 multiplier datapath.
package mod997_pkg;

  localparam int unsigned RES_W = 10;
  localparam logic [RES_W-1:0] MOD_997 = 10'd997;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Fold a raw RES_W-bit value into [0, MOD_997) with one conditional subtract.
  function automatic logic [RES_W-1:0] reduce_once(input logic [RES_W-1:0] x);
    return (x >= MOD_997) ? RES_W'(x - MOD_997) : x;
  endfunction

endpackage

// File: rtl/mod997_add.sv
// Combinational modular adder; both operands must already be < MOD.
module mod997_add #(
  parameter int unsigned W   = 10,
  parameter int unsigned MOD = 997
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c
);

  localparam logic [W:0] MOD_S = (W+1)'(MOD);

  logic [W:0] s;

  // Carry-preserving sum followed by a single conditional subtract.
  always_comb begin
    s     = {1'b0, a} + {1'b0, b};
    sum_c = (s >= MOD_S) ? W'(s - MOD_S) : W'(s);
  end

endmodule

// File: rtl/mod997_term_accumulator.sv
// Reduction tail of the digit-serial mod-997 multiplier: sums TERMS residues mod MOD.
module mod997_term_accumulator
  import mod997_pkg::*;
#(
  parameter int unsigned MOD   = 32'(MOD_997),
  parameter int unsigned W     = RES_W,
  parameter int unsigned TERMS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_term,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned CNT_W = $clog2(TERMS + 1);
  localparam logic [W-1:0]     MOD_W    = W'(MOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);

  acc_state_t       state, state_d;
  logic [W-1:0]     acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             err, err_d;
  logic [W-1:0]     out_res_d;
  logic             out_err_d;
  logic             term_oor;
  logic [W-1:0]     term_red;
  logic [W-1:0]     sum_c;

  // Fold an out-of-range term back into [0, MOD) before it reaches the adder.
  always_comb begin
    term_oor = (in_term >= MOD_W);
    term_red = term_oor ? W'(in_term - MOD_W) : in_term;
  end

  mod997_add #(
    .W   (W),
    .MOD (MOD)
  ) u_add (
    .a     (acc),
    .b     (term_red),
    .sum_c (sum_c)
  );

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    cnt_d     = cnt;
    err_d     = err;
    out_res_d = out_res;
    out_err_d = out_err;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_c;
          cnt_d = cnt + CNT_W'(1);
          err_d = err | term_oor;
          if (cnt == CNT_LAST) begin
            state_d   = DONE;
            out_res_d = sum_c;
            out_err_d = err | term_oor;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_res   <= '0;
      out_err   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      err       <= err_d;
      out_res   <= out_res_d;
      out_err   <= out_err_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mod997_term_accumulator.sv
// Bench for mod997_term_accumulator: vector table plus reset and back-pressure sequences.
module tb_mod997_term_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_term;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_res;
  logic       out_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0] res;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic [15:0][9:0] terms;
    logic             gap;
    logic [9:0]       res;
    logic             err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  mod997_term_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_term   (in_term),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of reduced terms, then a single % at the end.
  function automatic exp_t model(input logic [15:0][9:0] t);
    int   s;
    exp_t r;
    s     = 0;
    r.err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int v;
      v = int'(t[i]);
      if (v >= 997) begin
        v     = v - 997;
        r.err = 1'b1;
      end
      s = s + v;
    end
    r.res = 10'(s % 997);
    return r;
  endfunction

  // Run one operation: start, feed 16 terms, then hold out_ready low for 'hold' cycles.
  task automatic run_op(input logic [15:0][9:0] terms, input bit gap, input exp_t e, input int hold);
    int   j;
    int   cyc;
    bit   acc_now;
    exp_t got;
    logic [9:0] res_snap;
    logic       err_snap;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_busy", 32'(busy), 0);
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_ready", 32'(in_ready), 1);
    j   = 0;
    cyc = 0;
    while (j < 16 && cyc < 200) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_term  = terms[j];
      acc_now  = in_valid & in_ready;
      if (acc_now && j == 15) sb.push_back(e);
      @(negedge clk);
      cyc++;
      if (acc_now) j++;
      if (j < 16) check("no_early_valid", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    in_term  = 10'($urandom_range(0, 1023));
    if (j < 16) begin
      check("accept_timeout", 32'(j), 16);
    end else begin
      check("valid_latency", 32'(out_valid), 1);
      check("done_in_ready", 32'(in_ready), 0);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check("out_res", 32'(out_res), 32'(got.res));
        check("out_err", 32'(out_err), 32'(got.err));
      end
      res_snap = out_res;
      err_snap = out_err;
      for (int h = 0; h < hold; h++) begin
        start    = 1'b1;
        in_valid = 1'b1;
        in_term  = 10'd7;
        @(negedge clk);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_res_stable", 32'(out_res), 32'(res_snap));
        check("bp_err_stable", 32'(out_err), 32'(err_snap));
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_valid", 32'(out_valid), 0);
      check("drain_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    exp_t e;
    logic [15:0][9:0] ones;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_term   = '0;
    out_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      vecs[i] = '0;
    end
    for (int j = 0; j < 16; j++) begin
      vecs[0].terms[j] = 10'(j);
      vecs[1].terms[j] = 10'd996;
      vecs[6].terms[j] = 10'(j);
      vecs[7].terms[j] = 10'(j);
      vecs[8].terms[j] = 10'($urandom_range(0, 1023));
      vecs[9].terms[j] = 10'd1023;
    end
    vecs[0].res = 10'd120;
    vecs[1].res = 10'd981;
    vecs[2].terms[0] = 10'd996; vecs[2].terms[1] = 10'd1;   vecs[2].res = 10'd0;
    vecs[3].terms[0] = 10'd500; vecs[3].terms[1] = 10'd497; vecs[3].res = 10'd0;
    vecs[4].terms[0] = 10'd500; vecs[4].terms[1] = 10'd496; vecs[4].res = 10'd996;
    vecs[5].terms[0] = 10'd1000; vecs[5].res = 10'd3; vecs[5].err = 1'b1;
    vecs[6].res = 10'd120;
    vecs[7].res = 10'd120; vecs[7].gap = 1'b1;
    e = model(vecs[8].terms);
    vecs[8].res = e.res; vecs[8].err = e.err;
    vecs[9].res = 10'd416; vecs[9].err = 1'b1;

    #12;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_res", 32'(out_res), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.res = vecs[i].res;
      e.err = vecs[i].err;
      run_op(vecs[i].terms, vecs[i].gap, e, 0);
    end

    // Back-pressure: result held for five cycles while start and terms are offered.
    for (int j = 0; j < 16; j++) ones[j] = 10'd1;
    e.res = 10'd16;
    e.err = 1'b0;
    run_op(ones, 1'b0, e, 5);

    // Asynchronous reset after seven accepted terms.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      in_valid = 1'b1;
      in_term  = 10'd5;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ones, 1'b0, e, 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
